// File: rtl/cnt25_checker.sv
// Sequence checker for a mod-MODULUS counter stream: acquires lock after LOCK_LEN
// consecutive correct transitions, then flags and counts sequence errors.
module cnt25_checker #(
    parameter int unsigned MODULUS  = 25,
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       in_data,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [4:0]       expected
);

    localparam int unsigned DATA_W     = 5;
    localparam int unsigned DATA_EXT_W = DATA_W + 1;
    localparam int unsigned RUN_W      = 4;

    localparam logic [DATA_W-1:0]     LAST_VAL = DATA_W'(MODULUS - 1);
    localparam logic [DATA_EXT_W-1:0] MOD_EXT  = DATA_EXT_W'(MODULUS);
    localparam logic [RUN_W-1:0]      LOCK_RUN = RUN_W'(LOCK_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [DATA_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   chk_q, chk_d;
    logic               pulse_q, pulse_d;
    logic               locked_q, locked_d;

    logic               in_range;
    logic               match;
    logic [DATA_W-1:0]  next_of_in;
    logic [RUN_W-1:0]   run_inc;
    logic               err_inc;
    logic               chk_inc;

    function automatic logic [DATA_W-1:0] next_val(input logic [DATA_W-1:0] x);
        return (x == LAST_VAL) ? '0 : x + DATA_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_range   = {1'b0, in_data} < MOD_EXT;
    assign match      = (in_data == exp_q);
    assign next_of_in = next_val(in_data);
    assign run_inc    = run_q + RUN_W'(1);

    // Next-state, prediction and statistics update
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        exp_d   = exp_q;
        err_inc = 1'b0;
        chk_inc = 1'b0;
        pulse_d = 1'b0;

        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_range) begin
                        state_d = ST_ACQUIRE;
                        run_d   = '0;
                        exp_d   = next_of_in;
                    end
                end
                ST_ACQUIRE: begin
                    if (!in_range) begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end else if (match) begin
                        exp_d = next_of_in;
                        if (run_inc == LOCK_RUN) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                        exp_d = next_of_in;
                    end
                end
                ST_LOCKED: begin
                    chk_inc = 1'b1;
                    if (!in_range) begin
                        err_inc = 1'b1;
                        pulse_d = 1'b1;
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end else if (match) begin
                        exp_d = next_of_in;
                    end else begin
                        err_inc = 1'b1;
                        pulse_d = 1'b1;
                        state_d = ST_ACQUIRE;
                        run_d   = '0;
                        exp_d   = next_of_in;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end

        // clr wins over a same-cycle increment
        if (clr) begin
            err_d = '0;
            chk_d = '0;
        end else begin
            err_d = err_inc ? sat_inc(err_q) : err_q;
            chk_d = chk_inc ? sat_inc(chk_q) : chk_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            run_q    <= '0;
            exp_q    <= '0;
            err_q    <= '0;
            chk_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            chk_q    <= chk_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_cnt   = err_q;
    assign chk_cnt   = chk_q;
    assign expected  = exp_q;

endmodule

// File: tb/tb_cnt25_checker.sv
// Scoreboard bench for cnt25_checker: default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.
module tb_cnt25_checker;

    localparam int unsigned MOD  = 25;
    localparam int unsigned LLEN = 3;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [4:0] in_data;
    logic       clr;

    logic        locked, err_pulse;
    logic [15:0] err_cnt, chk_cnt;
    logic [4:0]  expected;

    logic        s_locked, s_err_pulse;
    logic [3:0]  s_err_cnt, s_chk_cnt;
    logic [4:0]  s_expected;

    cnt25_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .chk_cnt(chk_cnt), .expected(expected)
    );

    cnt25_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt),
        .chk_cnt(s_chk_cnt), .expected(s_expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       locked;
        logic       pulse;
        logic [4:0] exp_val;
        int         err;
        int         chk;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: 0 idle, 1 acquire, 2 locked; counters unbounded
    int         m_state;
    int         m_run;
    logic [4:0] m_exp;
    int         m_err;
    int         m_chk;
    logic       m_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        else
            n_pass++;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic logic [4:0] nxt(input logic [4:0] x);
        return (int'(x) == MOD - 1) ? 5'd0 : 5'(int'(x) + 1);
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_exp = '0; m_err = 0; m_chk = 0; m_pulse = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic v, input logic [4:0] d, input logic c);
        bit inr;
        inr = int'(d) < MOD;
        m_pulse = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                if (inr) begin m_state = 1; m_run = 0; m_exp = nxt(d); end
            end else if (m_state == 1) begin
                if (!inr) begin
                    m_state = 0; m_run = 0;
                end else if (d == m_exp) begin
                    m_run++;
                    m_exp = nxt(d);
                    if (m_run == LLEN) begin m_state = 2; m_run = 0; end
                end else begin
                    m_run = 0; m_exp = nxt(d);
                end
            end else begin
                m_chk++;
                if (!inr) begin
                    m_err++; m_pulse = 1'b1; m_state = 0; m_run = 0;
                end else if (d == m_exp) begin
                    m_exp = nxt(d);
                end else begin
                    m_err++; m_pulse = 1'b1; m_state = 1; m_run = 0; m_exp = nxt(d);
                end
            end
        end
        if (c) begin m_err = 0; m_chk = 0; end
    endtask

    task automatic step(input logic v, input logic [4:0] d, input logic c);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_data = d; clr = c;
        model_step(v, d, c);
        e.locked = (m_state == 2); e.pulse = m_pulse; e.exp_val = m_exp;
        e.err = m_err; e.chk = m_chk;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("locked",      locked,      e.locked);
        check("err_pulse",   err_pulse,   e.pulse);
        check("expected",    expected,    e.exp_val);
        check("err_cnt",     err_cnt,     sat(e.err, 65535));
        check("chk_cnt",     chk_cnt,     sat(e.chk, 65535));
        check("s_locked",    s_locked,    e.locked);
        check("s_expected",  s_expected,  e.exp_val);
        check("s_err_cnt",   s_err_cnt,   sat(e.err, 15));
        check("s_chk_cnt",   s_chk_cnt,   sat(e.chk, 15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int chk_before;
        int r;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clr = 1'b0;
        model_reset();
        #3;
        check("rst_locked",   locked,    0);
        check("rst_pulse",    err_pulse, 0);
        check("rst_expected", expected,  0);
        check("rst_err",      err_cnt,   0);
        check("rst_chk",      chk_cnt,   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Lock acquisition
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i), 1'b0);
        check("acq_locked", locked, 1);
        check("acq_exp",    expected, 4);
        check("acq_chk",    chk_cnt, 0);
        for (int i = 4; i < 23; i++) step(1'b1, 5'(i), 1'b0);
        check("pre_wrap_exp", expected, 23);

        // Wrap
        chk_before = m_chk;
        step(1'b1, 5'd23, 1'b0);
        step(1'b1, 5'd24, 1'b0);
        step(1'b1, 5'd0,  1'b0);
        step(1'b1, 5'd1,  1'b0);
        check("wrap_chk_delta", 32'(int'(chk_cnt) - chk_before), 4);
        check("wrap_exp",       expected, 2);
        check("wrap_err",       err_cnt, 0);

        // Mismatch in LOCKED, then re-lock
        for (int i = 2; i < 5; i++) step(1'b1, 5'(i), 1'b0);
        step(1'b1, 5'd7, 1'b0);
        check("mm_pulse",  err_pulse, 1);
        check("mm_err",    err_cnt, 1);
        check("mm_locked", locked, 0);
        check("mm_exp",    expected, 8);
        step(1'b0, 5'd3, 1'b0);
        for (int i = 8; i < 11; i++) step(1'b1, 5'(i), 1'b0);
        check("relock", locked, 1);

        // Out-of-range in LOCKED, gaps
        step(1'b1, 5'd30, 1'b0);
        check("oor_err",    err_cnt, 2);
        check("oor_locked", locked, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 5'($urandom_range(0, 31)), 1'b0);

        // Errors outside LOCKED are silent
        step(1'b1, 5'd31, 1'b0);
        step(1'b1, 5'd12, 1'b0);
        step(1'b1, 5'd14, 1'b0);
        step(1'b1, 5'd25, 1'b0);
        check("quiet_err", err_cnt, 2);

        // Saturation and clr
        step(1'b1, 5'd0, 1'b1);
        for (int i = 1; i < 4; i++) step(1'b1, 5'(i), 1'b0);
        for (int i = 4; i < 24; i++) step(1'b1, 5'(i), 1'b0);
        check("sat_chk16", chk_cnt, 20);
        check("sat_chk4",  s_chk_cnt, 15);
        step(1'b1, 5'd24, 1'b1);
        check("clr_chk", chk_cnt, 0);
        check("clr_locked", locked, 1);

        // Biased random traffic
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      step(1'b1, m_exp, ($urandom_range(0, 99) < 3));
            else if (r < 78) step(1'b0, 5'($urandom_range(0, 31)), ($urandom_range(0, 99) < 3));
            else if (r < 90) step(1'b1, 5'($urandom_range(0, MOD - 1)), 1'b0);
            else             step(1'b1, 5'($urandom_range(0, 31)), 1'b0);
        end

        // Async reset while LOCKED
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i), 1'b0);
        step(1'b1, 5'd4, 1'b0);
        check("pre_rst_locked", locked, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_locked",  locked,    0);
        check("arst_err",     err_cnt,   0);
        check("arst_chk",     chk_cnt,   0);
        check("arst_exp",     expected,  0);
        check("arst_s_chk",   s_chk_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 5'd10, 1'b0);
        check("post_rst_locked", locked, 0);
        check("post_rst_exp",    expected, 11);
        for (int i = 11; i < 14; i++) step(1'b1, 5'(i), 1'b0);
        check("post_rst_relock", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
